// File: rtl/ip_probe_display.sv
// On-board harness for pipelined arithmetic IP. It steps through a set of stimulus vectors,
// captures each result a fixed latency after issue, and shows the index and a pageable window of the result.
module ip_probe_display #(
  parameter int DATA_W     = 32,
  parameter int NUM_DIGITS = 6,
  parameter int LATENCY    = 6,
  parameter int NUM_VEC    = 16,
  parameter int DWELL      = 50000000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       run,
  input  logic                       page_btn,
  input  logic [DATA_W-1:0]          res_in,
  output logic [$clog2(NUM_VEC)-1:0] vec_idx,
  output logic                       issue,
  output logic                       done,
  output logic [7*NUM_DIGITS-1:0]    segments
);
  localparam int IDX_W     = $clog2(NUM_VEC);
  localparam int NIB       = DATA_W / 4;
  localparam int WIN       = NUM_DIGITS - 1;
  localparam int NUM_PAGES = (NIB + WIN - 1) / WIN;
  localparam int PAGE_W    = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;
  localparam int WCNT_W    = $clog2(LATENCY + 1);
  localparam int DCNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, SHOW} state_t;

  state_t                  state, state_next;
  logic [WCNT_W-1:0]       wait_cnt;
  logic [DCNT_W-1:0]       dwell_cnt;
  logic [DATA_W-1:0]       result;
  logic [PAGE_W-1:0]       page;
  logic [2:0]              btn_sync;
  logic                    page_step;
  logic                    capture, dwell_end, wrap;
  logic [7:0]              idx8;
  logic [7*NUM_DIGITS-1:0] seg_next;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;  4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;  4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;  4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;  4'hE: glyph = 7'h06;  4'hF: glyph = 7'h0E;
      default: glyph = 7'h7F;
    endcase
  endfunction

  // Decoded image of the all-zero reset state (page 0, index 0, result 0).
  function automatic logic [7*NUM_DIGITS-1:0] reset_pattern();
    logic [7*NUM_DIGITS-1:0] p;
    p = '1;
    p[6:0] = 7'h40;
    for (int unsigned k = 1; k < NUM_DIGITS; k++)
      if (k - 1 < NIB) p[7*k +: 7] = 7'h40;
    return p;
  endfunction

  localparam logic [7*NUM_DIGITS-1:0] SEG_RST = reset_pattern();

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    capture    = 1'b0;
    dwell_end  = 1'b0;
    case (state)
      IDLE:  if (run) state_next = ISSUE;
      ISSUE: begin
        issue      = 1'b1;
        state_next = WAIT;
      end
      WAIT:  if (wait_cnt == WCNT_W'(LATENCY)) begin
        capture    = 1'b1;
        state_next = SHOW;
      end
      SHOW:  if (dwell_cnt == DCNT_W'(DWELL - 1)) begin
        dwell_end  = 1'b1;
        state_next = run ? ISSUE : IDLE;
      end
      default: state_next = IDLE;
    endcase
    wrap = dwell_end && (vec_idx == IDX_W'(NUM_VEC - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      dwell_cnt <= '0;
      result    <= '0;
      vec_idx   <= '0;
      done      <= 1'b0;
    end else begin
      state <= state_next;
      done  <= wrap;
      if (state == ISSUE)      wait_cnt <= WCNT_W'(1);
      else if (capture)        wait_cnt <= '0;
      else if (state == WAIT)  wait_cnt <= wait_cnt + WCNT_W'(1);
      if (capture)             dwell_cnt <= '0;
      else if (state == SHOW)  dwell_cnt <= dwell_end ? '0 : dwell_cnt + DCNT_W'(1);
      if (capture)             result <= res_in;
      if (dwell_end)           vec_idx <= wrap ? '0 : vec_idx + IDX_W'(1);
    end
  end

  assign page_step = btn_sync[1] & ~btn_sync[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync <= '0;
      page     <= '0;
    end else begin
      btn_sync <= {btn_sync[1:0], page_btn};
      if (page_step) page <= (page == PAGE_W'(NUM_PAGES - 1)) ? '0 : page + PAGE_W'(1);
    end
  end

  always_comb begin
    seg_next      = '1;
    idx8          = 8'(vec_idx);
    seg_next[6:0] = glyph(idx8[3:0]);
    for (int unsigned k = 1; k < NUM_DIGITS; k++) begin
      int unsigned n;
      n = 32'(page) * WIN + (k - 1);
      if (n < NIB) seg_next[7*k +: 7] = glyph(result[4*n +: 4]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) segments <= SEG_RST;
    else        segments <= seg_next;
  end

endmodule

// File: tb/tb_ip_probe_display.sv
// Directed bench for ip_probe_display: the stepping and capture timing, result paging, reset mid-wait,
// and capture-cycle exactness.
module tb_ip_probe_display;
  localparam int DATA_W = 32, ND = 6, LAT = 3, NV = 4, DW = 4;
  localparam logic [6:0] BL = 7'h7F;

  logic        clk = 1'b0;
  logic        rst_n, run, page_btn;
  logic [31:0] res_in;
  logic [1:0]  vec_idx;
  logic        issue, done;
  logic [41:0] segments;

  logic        use_model;
  logic [31:0] manual, p1, p2, p3;
  int          n_cmp = 0, n_bad = 0;
  int          issue_cnt, done_cnt, found;

  logic [6:0] G [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                         7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int exp_t [7] = '{1, 9, 17, 25, 33, 41, 49};
  int exp_i [7] = '{0, 1, 2, 3, 0, 1, 2};

  always #5 clk = ~clk;

  // Stand-in for the IP under test: a 3-stage delay of a per-index constant.
  always @(posedge clk) begin
    p1 <= 32'h12345670 + 32'(vec_idx);
    p2 <= p1;
    p3 <= p2;
  end
  assign res_in = use_model ? p3 : manual;

  ip_probe_display #(
    .DATA_W(DATA_W), .NUM_DIGITS(ND), .LATENCY(LAT), .NUM_VEC(NV), .DWELL(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .page_btn(page_btn), .res_in(res_in),
    .vec_idx(vec_idx), .issue(issue), .done(done), .segments(segments)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [41:0] seg6(input logic [6:0] a5, a4, a3, a2, a1, a0);
    return {a5, a4, a3, a2, a1, a0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; page_btn = 1'b0; use_model = 1'b1; manual = '0;
    repeat (3) step();
    check("rst_seg", segments, seg6(G[0], G[0], G[0], G[0], G[0], G[0]));
    check("rst_issue", issue, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    issue_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (issue) issue_cnt++;
    end
    check("idle_no_issue", issue_cnt, 0);
    check("idle_idx", vec_idx, 0);
    check("idle_seg", segments, seg6(G[0], G[0], G[0], G[0], G[0], G[0]));

    // Free run from IDLE; run is dropped during the WAIT of the second idx 2.
    issue_cnt = 0; done_cnt = 0;
    run = 1'b1;
    for (int t = 1; t <= 80; t++) begin
      step();
      if (issue) begin
        if (issue_cnt < 7) begin
          check("issue_t", t, exp_t[issue_cnt]);
          check("issue_idx", vec_idx, exp_i[issue_cnt]);
        end
        issue_cnt++;
      end
      if (done) begin
        done_cnt++;
        check("done_t", t, 33);
        check("done_idx", vec_idx, 0);
      end
      for (int k = 0; k < 7; k++) begin
        if (t == exp_t[k] + 3)
          check("hold", dut.result, (k == 0) ? 32'h0 : 32'h12345670 + exp_i[(k > 0) ? k - 1 : 0]);
        if (t == exp_t[k] + 4)
          check("capture", dut.result, 32'h12345670 + exp_i[k]);
      end
      if (t == 13) check("seg_lag", segments, seg6(G[4], G[5], G[6], G[7], G[0], G[1]));
      if (t == 14) check("seg_idx1", segments, seg6(G[4], G[5], G[6], G[7], G[1], G[1]));
      if (t == 50) run = 1'b0;
      if (t == 57) check("stop_idx", vec_idx, 3);
    end
    check("issue_cnt", issue_cnt, 7);
    check("done_cnt", done_cnt, 1);
    check("stop_result", dut.result, 32'h12345672);

    // Paging with result 12345672 held in IDLE at index 3.
    check("seg_p0", segments, seg6(G[4], G[5], G[6], G[7], G[2], G[3]));
    page_btn = 1'b1; step(); page_btn = 1'b0;
    step();
    check("page_early", dut.page, 0);
    step();
    check("page_edge", dut.page, 1);
    step();
    check("seg_p1", segments, seg6(BL, BL, G[1], G[2], G[3], G[3]));
    page_btn = 1'b1; step(); page_btn = 1'b0;
    repeat (2) step();
    step();
    check("page_wrap", dut.page, 0);
    step();
    check("seg_p0_again", segments, seg6(G[4], G[5], G[6], G[7], G[2], G[3]));
    page_btn = 1'b1; step(); page_btn = 1'b0; step(); page_btn = 1'b1; step(); page_btn = 1'b0;
    check("b2b_first", dut.page, 1);
    step(); step();
    check("b2b_second", dut.page, 0);
    page_btn = 1'b1; step(); page_btn = 1'b0;
    repeat (3) step();
    check("page_set", dut.page, 1);

    // Reset during WAIT of idx 1.
    run = 1'b1; found = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (issue && vec_idx == 2'd1) begin
        found = 1;
        break;
      end
    end
    check("find_idx1", found, 1);
    step(); step();
    rst_n = 1'b0;
    #1;
    check("mid_rst_issue", issue, 0);
    check("mid_rst_idx", vec_idx, 0);
    check("mid_rst_result", dut.result, 0);
    check("mid_rst_page", dut.page, 0);
    check("mid_rst_seg", segments, seg6(G[0], G[0], G[0], G[0], G[0], G[0]));
    step();
    check("mid_rst_hold", issue, 0);
    use_model = 1'b0; manual = 32'hDEAD0001;
    rst_n = 1'b1;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (issue) begin
        found = 1;
        break;
      end
    end
    check("post_rst_issue", found, 1);
    check("post_rst_idx", vec_idx, 0);
    check("post_rst_result", dut.result, 0);

    // Only the value present exactly LATENCY cycles after issue may be captured.
    step();                          // c+1
    step(); manual = 32'hBAD00002;   // c+2
    step(); manual = 32'hC0FFEE33;   // c+3
    step();                          // c+4
    check("marker", dut.result, 32'hC0FFEE33);
    manual = 32'hBAD00004;
    step(); step();
    check("marker_kept", dut.result, 32'hC0FFEE33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ip_probe_display.md
# ip_probe_display

Parametrised on-board test harness for pipelined arithmetic IP such as the float/int converters. It steps a vector index through `NUM_VEC` stimuli, one at a time, and issues each to the IP under test. It captures the IP result exactly `LATENCY` cycles after issue and shows the index and a pageable window of the result on `NUM_DIGITS` seven-segment displays. It sits between the board clock, push-button and displays and the IP under test.

## Interface
- `DATA_W`, 32, result width in bits (multiple of 4, 4..64)
- `NUM_DIGITS`, 6, number of seven-segment digits (2..8)
- `LATENCY`, 6, IP pipeline latency in cycles (>=1)
- `NUM_VEC`, 16, number of stimulus vectors (2..256)
- `DWELL`, 50000000, cycles each captured result is held before the next issue (>=1)
- `clk  in  1`  board clock, all logic on rising edge
- `rst_n  in  1`  asynchronous, active-low reset
- `run  in  1`  level; enables stepping through vectors
- `page_btn  in  1`  raw push-button, asynchronous, active-high
- `res_in  in  DATA_W`  result from IP under test
- `vec_idx  out  clog2(NUM_VEC)`  current stimulus index, drives external stimulus mux
- `issue  out  1`  one-cycle pulse: stimulus for `vec_idx` is valid this cycle
- `done  out  1`  one-cycle pulse at end of last vector's dwell
- `segments  out  7*NUM_DIGITS`  digit k at bits [7k+6:7k], bit0=a … bit6=g, active-low

## Operation
- FSM states: IDLE, ISSUE, WAIT, SHOW.
- IDLE: if `run`=1, go to ISSUE next cycle. Otherwise stay.
- ISSUE lasts one cycle with `issue`=1, then WAIT with `wait_cnt`=1.
- WAIT: `wait_cnt` increments each cycle. When `wait_cnt`=LATENCY, load `res_in` into `result` on that edge and go to SHOW with `dwell_cnt`=0.
- SHOW: `dwell_cnt` increments. At `dwell_cnt`=DWELL-1:
  - `vec_idx` advances, wrapping from NUM_VEC-1 to 0.
  - If the wrap occurred, `done` pulses.
  - Next state is ISSUE if `run`=1, else IDLE.
- Deasserting `run` in ISSUE, WAIT or SHOW does not abort. The current vector completes capture and dwell, then the FSM goes to IDLE with `vec_idx` already advanced.
- `page_btn`: 2-flop synchroniser plus rising-edge detect.
  - Each edge advances `page`, wrapping from NUM_PAGES-1 to 0.
  - `NUM_PAGES` = ceil((DATA_W/4)/(NUM_DIGITS-1)).
  - Page changes are independent of FSM state.
- Display mapping:
  - Digit 0 shows `vec_idx[3:0]`.
  - Digit k (1..NUM_DIGITS-1) shows nibble n = page*(NUM_DIGITS-1)+(k-1) of `result`.
  - If n >= DATA_W/4, the digit is blank (7'h7F).
- Glyphs are standard hex, active-low: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E.
- `segments` is registered and decoded from the current `vec_idx`, `result` and `page`.

## Timing
- Reset values (asynchronous assertion, synchronous release):
  - state IDLE; `vec_idx`, `result`, `page` and all counters 0; `issue`=0, `done`=0.
  - `segments`: in-range digits 7'h40, out-of-range digits 7'h7F.
- Issue-to-capture: `issue` is high in cycle c. `result` takes the value `res_in` had in cycle c+LATENCY, visible from cycle c+LATENCY+1.
- `segments` lags its sources by exactly one cycle.
- Vector period is 1+LATENCY+DWELL cycles while `run`=1. No idle cycle occurs between SHOW and the next ISSUE.
- `done` and the `vec_idx` wrap occur on the same edge.
- Button edge to `page` update takes 3 cycles (2 sync + 1 edge detect). Back-to-back edges one cycle apart each count.
- Reset asserted mid-WAIT: no capture, `issue` low immediately, and the FSM restarts from IDLE with index 0.

## Test plan
Parameters for all scenarios: DATA_W=32, NUM_DIGITS=6, LATENCY=3, NUM_VEC=4, DWELL=4. The IP model is a 3-stage delay of 32'h12345670+idx.
- Reset, `run`=0 -> `segments` digits 0-5 = 7'h40; `issue`=0; state stays IDLE for 20 cycles.
- `run`=1 from reset -> `issue` pulses every 8 cycles with `vec_idx` 0,1,2,3. `result` becomes 32'h12345670, then …71, …72, …73. `done` pulses once, coincident with `vec_idx` 3->0.
- After capture of idx 1, digits 1-5 = 1,7,6,5,4 (7'h79,7'h78,7'h02,7'h12,7'h19). After one `page_btn` edge: digits 1-5 = 3,2,1,blank,blank. After a second edge: back to page 0.
- Drop `run` during WAIT of idx 2 -> idx 2 captured (…72), dwell completes, FSM goes to IDLE with `vec_idx`=3 and no further `issue`.
- Assert `rst_n`=0 during WAIT of idx 1, then release -> `result`=0, `vec_idx`=0, `page`=0; the next `issue` after `run` carries idx 0.
- Drive `res_in` with a marker only in cycle c+3 and garbage in c+2 and c+4 -> only the marker is captured.
